fetch_decode_execute: RTL and testbench
=======================================

FETCH_DECODE_EXECUTE -- requirements
Module: fetch_decode_execute

Interface
REQ-001 SHALL have parameters: BASE_ADDR, 32'h80020000, reset PC; SP_INIT, 32'h80120000, reset r29; RA_INIT, 32'hdeadbeef, reset r31.
REQ-002 SHALL have ports, clock and reset first:
- clock  in  1  single clock; all state updates on posedge.
- reset  in  1  synchronous, active-high.
- i_address  out  32  fetch address.
- i_access_size  out  2  fixed 2'b00 (word).
- i_rw  out  1  fixed 1 (read).
- i_mem_enable  out  1  fixed 1.
- i_data_out  in  32  instruction at i_address, same cycle.
- wb_we  in  1  register write enable.
- wb_rd  in  5  write register.
- wb_data  in  32  write data.
- mx_data, wx_data  in  32  bypass values.
- do_mx_bypass, do_wx_bypass  in  1  operand-A bypass selects.
- do_mx_bypass_b, do_wx_bypass_b  in  1  operand-B bypass selects.
- ir_dx  out  32  D/X instruction.
- dmwe_dx, rwe_dx, rdst_dx, rwd_dx  out  1  D/X controls.
- aluOut, rBOut  out  32  ALU result; forwarded rB as store data.
- pc_effective  out  32  redirect target.
- do_branch  out  1  redirect taken.
- stall  out  1  load-use stall.

Function
REQ-003 Fetch SHALL hold PC; i_address = PC; the fetched instruction is decoded in the same cycle (F/D combined).
REQ-004 Each posedge, next PC SHALL be: pc_effective if do_branch; else PC if stall; else PC+4, wrapping mod 2^32.
REQ-005 Decode SHALL hold a 32x32 register file; r0 reads 0 and ignores writes.
REQ-006 Read ports SHALL be combinational on rs[25:21] and rt[20:16], with a same-cycle write to the read register (wb_we=1, wb_rd≠0) returning wb_data.
REQ-007 Decode SHALL produce br, jp, aluinb (1 = sign-extended immediate), aluop, dmwe, rwe, rdst (1 = rd[15:11], 0 = rt), and rwd (1 = load data).
- aluop = funct for R-type; ADDIU/LW/SW map to 100001.
- Unknown opcodes decode as bubble: aluop 100001, all controls 0.
REQ-008 Supported instructions: ADDU, SUBU, AND, OR, XOR, SLT, SLL, SRL, JR, ADDIU, LUI, LW, SW, BEQ, BNE, J.
REQ-009 The D/X register SHALL capture pc, IR, rA, rB and all controls each posedge.
- On stall or do_branch it SHALL capture a bubble: IR 0, pc 0, rA/rB 0, aluop 100001, all controls 0.
- do_branch has priority over stall.
REQ-010 Execute SHALL be combinational from D/X.
- Operand A = mx_data if do_mx_bypass, else wx_data if do_wx_bypass, else rA; B likewise with the _b selects.
- MX has priority over WX.
REQ-011 aluOut SHALL be 32-bit, carries discarded; SLT signed; shifts use IR[10:6]; LUI = imm<<16.
REQ-012 pc_effective SHALL be:
- BEQ/BNE: pc+4+(sext(imm)<<2).
- J: {(pc+4)[31:28], IR[25:0], 2'b00}.
- JR: operand A.
REQ-013 do_branch SHALL be 1 for taken BEQ/BNE, J and JR; the penalty is 1 bubble.
REQ-014 stall SHALL be 1 when IR_DX opcode is LW (100011) and either:
- i_data_out rs equals the load destination rt, or
- i_data_out rt equals the load destination rt and the decoded opcode is not SW (101011).
The penalty is 1 bubble.

Reset
REQ-015 On reset the block SHALL set:
- PC = BASE_ADDR.
- D/X = bubble, so all outputs are derived from the bubble: do_branch 0, stall 0.
- All registers 0, except r29 = SP_INIT and r31 = RA_INIT.
REQ-016 Reset SHALL override stall and do_branch in the same cycle.

Configuration
REQ-017 When FDX_DEBUG_EN is defined, each posedge SHALL $display F/D PC/IR and D/X PC/IR. When undefined, the block is silent and the RTL is otherwise identical.

Structure
REQ-018 A shared package SHALL hold the opcode/funct constants, NOP_OP = 6'b100001, and the bubble value.
REQ-019 The register file SHALL be a sub-module regfile; fetch, decode, D/X and execute SHALL be inline.

Verification
REQ-020 Reset -> i_address = 0x80020000, then 0x80020004 and 0x80020008 on the following cycles; r29 = 0x80120000, r31 = 0xdeadbeef.
REQ-021 ADDIU r8,r0,5 then ADDU r9,r8,r8 with do_mx_bypass=do_mx_bypass_b=1, mx_data=5 -> aluOut=10.
REQ-022 LW r8 followed by ADDU r9,r8,r0 -> stall=1 for one cycle, PC held, one bubble in D/X; SW r8 after LW r8 (rt match) -> no stall.
REQ-023 BEQ r0,r0,+3 at 0x80020010 -> do_branch=1, pc_effective=0x80020020, next i_address=0x80020020, one bubble.
REQ-024 J 0x0008010 at PC 0x80020000 -> pc_effective=0x80020040; JR with operand A=0x80020100 -> redirect to 0x80020100.
REQ-025 wb_we=1, wb_rd=0, wb_data=0xffffffff -> r0 still reads 0; same write to r5 with r5 read in that cycle -> reads 0xffffffff.

Source files
------------

// File: rtl/fetch_decode_execute_pkg.sv
// Shared constants and types for the fetch/decode/execute front end:
// opcode/funct encodings, decoded control bundle and the D/X bubble value.
package fetch_decode_execute_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDIU = 6'b001001;
  localparam logic [5:0] OP_LUI   = 6'b001111;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  localparam logic [5:0] FN_SLL  = 6'b000000;
  localparam logic [5:0] FN_SRL  = 6'b000010;
  localparam logic [5:0] FN_JR   = 6'b001000;
  localparam logic [5:0] FN_ADDU = 6'b100001;
  localparam logic [5:0] FN_SUBU = 6'b100011;
  localparam logic [5:0] FN_AND  = 6'b100100;
  localparam logic [5:0] FN_OR   = 6'b100101;
  localparam logic [5:0] FN_XOR  = 6'b100110;
  localparam logic [5:0] FN_SLT  = 6'b101010;

  localparam logic [5:0] NOP_OP = 6'b100001;

  typedef struct packed {
    logic [5:0] aluop;
    logic       br;
    logic       jp;
    logic       aluinb;
    logic       dmwe;
    logic       rwe;
    logic       rdst;
    logic       rwd;
  } ctrl_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] ir;
    logic [31:0] ra;
    logic [31:0] rb;
    ctrl_t       ctrl;
  } dx_t;

  localparam ctrl_t CTRL_BUBBLE = '{
    aluop: NOP_OP, br: 1'b0, jp: 1'b0, aluinb: 1'b0,
    dmwe: 1'b0, rwe: 1'b0, rdst: 1'b0, rwd: 1'b0
  };

  localparam dx_t DX_BUBBLE = '{
    pc: 32'h0000_0000, ir: 32'h0000_0000, ra: 32'h0000_0000,
    rb: 32'h0000_0000, ctrl: CTRL_BUBBLE
  };

  function automatic logic [31:0] sext16(input logic [15:0] imm);
    return {{16{imm[15]}}, imm};
  endfunction

endpackage

// File: rtl/fetch_decode_execute_regfile.sv
// 32x32 register file: two combinational read ports with write-through of a
// same-cycle write, r0 hard-wired to zero, r29/r31 preset on reset.
module fetch_decode_execute_regfile
  import fetch_decode_execute_pkg::*;
#(
  parameter logic [31:0] SP_INIT = 32'h8012_0000,
  parameter logic [31:0] RA_INIT = 32'hdead_beef
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [4:0]  rs_i,
  input  logic [4:0]  rt_i,
  output logic [31:0] rs_data_o,
  output logic [31:0] rt_data_o,
  input  logic        we_i,
  input  logic [4:0]  rd_i,
  input  logic [31:0] wd_i
);

  logic [31:0] regs_q [32];

  // Register storage with reset presets; writes to r0 are dropped.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < 32; i++) begin
        if (i == 29) begin
          regs_q[i] <= SP_INIT;
        end else if (i == 31) begin
          regs_q[i] <= RA_INIT;
        end else begin
          regs_q[i] <= 32'h0000_0000;
        end
      end
    end else if (we_i && (rd_i != 5'd0)) begin
      regs_q[rd_i] <= wd_i;
    end
  end

  // Port A read with write-through.
  always_comb begin
    rs_data_o = regs_q[rs_i];
    if (rs_i == 5'd0) begin
      rs_data_o = 32'h0000_0000;
    end else if (we_i && (rd_i == rs_i)) begin
      rs_data_o = wd_i;
    end else begin
      rs_data_o = regs_q[rs_i];
    end
  end

  // Port B read with write-through.
  always_comb begin
    rt_data_o = regs_q[rt_i];
    if (rt_i == 5'd0) begin
      rt_data_o = 32'h0000_0000;
    end else if (we_i && (rd_i == rt_i)) begin
      rt_data_o = wd_i;
    end else begin
      rt_data_o = regs_q[rt_i];
    end
  end

endmodule

// File: rtl/fetch_decode_execute.sv
// Combined fetch/decode stage, D/X pipeline register and execute stage.
// Define FDX_DEBUG_EN to print the F/D and D/X PC/IR on every clock edge.
module fetch_decode_execute
  import fetch_decode_execute_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h8002_0000,
  parameter logic [31:0] SP_INIT   = 32'h8012_0000,
  parameter logic [31:0] RA_INIT   = 32'hdead_beef
) (
  input  logic        clock,
  input  logic        reset,
  output logic [31:0] i_address,
  output logic [1:0]  i_access_size,
  output logic        i_rw,
  output logic        i_mem_enable,
  input  logic [31:0] i_data_out,
  input  logic        wb_we,
  input  logic [4:0]  wb_rd,
  input  logic [31:0] wb_data,
  input  logic [31:0] mx_data,
  input  logic [31:0] wx_data,
  input  logic        do_mx_bypass,
  input  logic        do_wx_bypass,
  input  logic        do_mx_bypass_b,
  input  logic        do_wx_bypass_b,
  output logic [31:0] ir_dx,
  output logic        dmwe_dx,
  output logic        rwe_dx,
  output logic        rdst_dx,
  output logic        rwd_dx,
  output logic [31:0] aluOut,
  output logic [31:0] rBOut,
  output logic [31:0] pc_effective,
  output logic        do_branch,
  output logic        stall
);

  logic [31:0] pc_q, pc_d;
  dx_t         dx_q, dx_d;
  ctrl_t       ctrl_fd;
  logic [31:0] rs_val, rt_val;
  logic [5:0]  opcode_fd, funct_fd;
  logic [4:0]  rs_fd, rt_fd;
  logic [5:0]  opcode_dx;
  logic [4:0]  rt_dx, shamt_dx;
  logic [31:0] imm_dx, pc4_dx;
  logic [31:0] op_a, op_b, alu_b;

  assign i_address     = pc_q;
  assign i_access_size = 2'b00;
  assign i_rw          = 1'b1;
  assign i_mem_enable  = 1'b1;

  assign opcode_fd = i_data_out[31:26];
  assign rs_fd     = i_data_out[25:21];
  assign rt_fd     = i_data_out[20:16];
  assign funct_fd  = i_data_out[5:0];

  // Next PC: redirect beats load-use hold beats sequential fetch.
  always_comb begin
    pc_d = pc_q + 32'd4;
    if (do_branch) begin
      pc_d = pc_effective;
    end else if (stall) begin
      pc_d = pc_q;
    end else begin
      pc_d = pc_q + 32'd4;
    end
  end

  // PC register.
  always_ff @(posedge clock) begin
    if (reset) begin
      pc_q <= BASE_ADDR;
    end else begin
      pc_q <= pc_d;
    end
  end

  fetch_decode_execute_regfile #(
    .SP_INIT (SP_INIT),
    .RA_INIT (RA_INIT)
  ) u_regfile (
    .clock     (clock),
    .reset     (reset),
    .rs_i      (rs_fd),
    .rt_i      (rt_fd),
    .rs_data_o (rs_val),
    .rt_data_o (rt_val),
    .we_i      (wb_we),
    .rd_i      (wb_rd),
    .wd_i      (wb_data)
  );

  // Instruction decode; anything unrecognised becomes a bubble.
  always_comb begin
    ctrl_fd = CTRL_BUBBLE;
    case (opcode_fd)
      OP_RTYPE: begin
        case (funct_fd)
          FN_ADDU, FN_SUBU, FN_AND, FN_OR, FN_XOR, FN_SLT, FN_SLL, FN_SRL: begin
            ctrl_fd.aluop = funct_fd;
            ctrl_fd.rwe   = 1'b1;
            ctrl_fd.rdst  = 1'b1;
          end
          FN_JR: begin
            ctrl_fd.aluop = funct_fd;
            ctrl_fd.jp    = 1'b1;
          end
          default: ctrl_fd = CTRL_BUBBLE;
        endcase
      end
      OP_ADDIU, OP_LUI: begin
        ctrl_fd.aluinb = 1'b1;
        ctrl_fd.rwe    = 1'b1;
      end
      OP_LW: begin
        ctrl_fd.aluinb = 1'b1;
        ctrl_fd.rwe    = 1'b1;
        ctrl_fd.rwd    = 1'b1;
      end
      OP_SW: begin
        ctrl_fd.aluinb = 1'b1;
        ctrl_fd.dmwe   = 1'b1;
      end
      OP_BEQ, OP_BNE: begin
        ctrl_fd.br = 1'b1;
      end
      OP_J: begin
        ctrl_fd.jp = 1'b1;
      end
      default: ctrl_fd = CTRL_BUBBLE;
    endcase
  end

  // Load-use hazard: a store may consume the loaded value as its data operand later.
  always_comb begin
    stall = 1'b0;
    if (opcode_dx == OP_LW) begin
      if (rs_fd == rt_dx) begin
        stall = 1'b1;
      end else if ((rt_fd == rt_dx) && (opcode_fd != OP_SW)) begin
        stall = 1'b1;
      end else begin
        stall = 1'b0;
      end
    end else begin
      stall = 1'b0;
    end
  end

  // D/X capture, squashed to a bubble on redirect or stall.
  always_comb begin
    dx_d = '{pc: pc_q, ir: i_data_out, ra: rs_val, rb: rt_val, ctrl: ctrl_fd};
    if (do_branch || stall) begin
      dx_d = DX_BUBBLE;
    end else begin
      dx_d = '{pc: pc_q, ir: i_data_out, ra: rs_val, rb: rt_val, ctrl: ctrl_fd};
    end
  end

  // D/X pipeline register.
  always_ff @(posedge clock) begin
    if (reset) begin
      dx_q <= DX_BUBBLE;
    end else begin
      dx_q <= dx_d;
    end
  end

  assign ir_dx    = dx_q.ir;
  assign dmwe_dx  = dx_q.ctrl.dmwe;
  assign rwe_dx   = dx_q.ctrl.rwe;
  assign rdst_dx  = dx_q.ctrl.rdst;
  assign rwd_dx   = dx_q.ctrl.rwd;

  assign opcode_dx = dx_q.ir[31:26];
  assign rt_dx     = dx_q.ir[20:16];
  assign shamt_dx  = dx_q.ir[10:6];
  assign imm_dx    = sext16(dx_q.ir[15:0]);
  assign pc4_dx    = dx_q.pc + 32'd4;

  // Operand forwarding; the MX path is younger and wins over WX.
  always_comb begin
    op_a = dx_q.ra;
    if (do_mx_bypass) begin
      op_a = mx_data;
    end else if (do_wx_bypass) begin
      op_a = wx_data;
    end else begin
      op_a = dx_q.ra;
    end
    op_b = dx_q.rb;
    if (do_mx_bypass_b) begin
      op_b = mx_data;
    end else if (do_wx_bypass_b) begin
      op_b = wx_data;
    end else begin
      op_b = dx_q.rb;
    end
  end

  assign alu_b = dx_q.ctrl.aluinb ? imm_dx : op_b;
  assign rBOut = op_b;

  // ALU.
  always_comb begin
    aluOut = op_a + alu_b;
    if (opcode_dx == OP_LUI) begin
      aluOut = {dx_q.ir[15:0], 16'h0000};
    end else begin
      case (dx_q.ctrl.aluop)
        FN_ADDU: aluOut = op_a + alu_b;
        FN_SUBU: aluOut = op_a - alu_b;
        FN_AND:  aluOut = op_a & alu_b;
        FN_OR:   aluOut = op_a | alu_b;
        FN_XOR:  aluOut = op_a ^ alu_b;
        FN_SLT:  aluOut = ($signed(op_a) < $signed(alu_b)) ? 32'd1 : 32'd0;
        FN_SLL:  aluOut = alu_b << shamt_dx;
        FN_SRL:  aluOut = alu_b >> shamt_dx;
        default: aluOut = op_a + alu_b;
      endcase
    end
  end

  // Redirect resolution for conditional branches, J and JR.
  always_comb begin
    pc_effective = pc4_dx;
    do_branch    = 1'b0;
    if (dx_q.ctrl.br) begin
      pc_effective = pc4_dx + (imm_dx << 2);
      if (opcode_dx == OP_BEQ) begin
        do_branch = (op_a == op_b);
      end else begin
        do_branch = (op_a != op_b);
      end
    end else if (dx_q.ctrl.jp) begin
      do_branch = 1'b1;
      if (opcode_dx == OP_J) begin
        pc_effective = {pc4_dx[31:28], dx_q.ir[25:0], 2'b00};
      end else begin
        pc_effective = op_a;
      end
    end else begin
      pc_effective = pc4_dx;
      do_branch    = 1'b0;
    end
  end

`ifdef FDX_DEBUG_EN
  // Per-cycle pipeline trace.
  always_ff @(posedge clock) begin
    $display("fdx: F/D pc=%h ir=%h | D/X pc=%h ir=%h", pc_q, i_data_out, dx_q.pc, dx_q.ir);
  end
`else
`endif

endmodule

// File: tb/tb_fetch_decode_execute.sv
// Table-driven directed bench for fetch_decode_execute plus reset-override sequences.
module tb_fetch_decode_execute;

  logic        clock = 1'b0;
  logic        reset;
  logic [31:0] i_address;
  logic [1:0]  i_access_size;
  logic        i_rw, i_mem_enable;
  logic [31:0] i_data_out;
  logic        wb_we;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data, mx_data, wx_data;
  logic        do_mx_bypass, do_wx_bypass, do_mx_bypass_b, do_wx_bypass_b;
  logic [31:0] ir_dx;
  logic        dmwe_dx, rwe_dx, rdst_dx, rwd_dx;
  logic [31:0] aluOut, rBOut, pc_effective;
  logic        do_branch, stall;

  int n_pass = 0;
  int n_total = 0;

  always #5 clock = ~clock;

  fetch_decode_execute dut (
    .clock(clock), .reset(reset),
    .i_address(i_address), .i_access_size(i_access_size), .i_rw(i_rw),
    .i_mem_enable(i_mem_enable), .i_data_out(i_data_out),
    .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data),
    .mx_data(mx_data), .wx_data(wx_data),
    .do_mx_bypass(do_mx_bypass), .do_wx_bypass(do_wx_bypass),
    .do_mx_bypass_b(do_mx_bypass_b), .do_wx_bypass_b(do_wx_bypass_b),
    .ir_dx(ir_dx), .dmwe_dx(dmwe_dx), .rwe_dx(rwe_dx), .rdst_dx(rdst_dx), .rwd_dx(rwd_dx),
    .aluOut(aluOut), .rBOut(rBOut), .pc_effective(pc_effective),
    .do_branch(do_branch), .stall(stall)
  );

  typedef struct {
    logic [31:0] instr;
    logic [3:0]  byp;     // {mx_a, wx_a, mx_b, wx_b}
    logic [31:0] mx, wx;
    logic        wbe;
    logic [4:0]  wbrd;
    logic [31:0] wbd;
    logic [31:0] e_addr, e_ir;
    logic        chk_alu;
    logic [31:0] e_alu;
    logic [3:0]  e_ctl;   // {dmwe, rwe, rdst, rwd}
    logic        e_stall, e_br;
    logic [1:0]  aux_sel; // 1: pc_effective, 2: rBOut
    logic [31:0] e_aux;
  } vec_t;

  localparam int NV = 29;
  vec_t vecs [NV];

  function automatic vec_t mk(
      input logic [31:0] instr, input logic [3:0] byp, input logic [31:0] mx, input logic [31:0] wx,
      input logic wbe, input logic [4:0] wbrd, input logic [31:0] wbd,
      input logic [31:0] e_addr, input logic [31:0] e_ir, input logic chk_alu, input logic [31:0] e_alu,
      input logic [3:0] e_ctl, input logic e_stall, input logic e_br,
      input logic [1:0] aux_sel, input logic [31:0] e_aux);
    vec_t v;
    v.instr = instr; v.byp = byp; v.mx = mx; v.wx = wx;
    v.wbe = wbe; v.wbrd = wbrd; v.wbd = wbd;
    v.e_addr = e_addr; v.e_ir = e_ir; v.chk_alu = chk_alu; v.e_alu = e_alu;
    v.e_ctl = e_ctl; v.e_stall = e_stall; v.e_br = e_br;
    v.aux_sel = aux_sel; v.e_aux = e_aux;
    return v;
  endfunction

  task automatic check(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s[%0d]: got %h expected %h", name, idx, act, exp);
    end
  endtask

  task automatic drive_idle();
    i_data_out = 32'h0; wb_we = 1'b0; wb_rd = 5'd0; wb_data = 32'h0;
    mx_data = 32'h0; wx_data = 32'h0;
    do_mx_bypass = 1'b0; do_wx_bypass = 1'b0; do_mx_bypass_b = 1'b0; do_wx_bypass_b = 1'b0;
  endtask

  initial begin
    //            instr         byp    mx            wx            we  rd     wbd           addr          ir_dx         ca   alu           ctl     st    br    aux   aux_val
    vecs[0]  = mk(32'h24080005, 4'h0, 32'h0,        32'h0,        1'b0, 5'd0, 32'h0,        32'h80020000, 32'h00000000, 1'b1, 32'h00000000, 4'b0000, 1'b0, 1'b0, 2'd0, 32'h0);
    vecs[1]  = mk(32'h01084821, 4'h0, 32'h0,        32'h0,        1'b0, 5'd0, 32'h0,        32'h80020004, 32'h24080005, 1'b1, 32'h00000005, 4'b0100, 1'b0, 1'b0, 2'd0, 32'h0);
    vecs[2]  = mk(32'h03A01021, 4'hF, 32'h5,        32'h100,      1'b1, 5'd8, 32'h5,        32'h80020008, 32'h01084821, 1'b1, 32'h0000000A, 4'b0110, 1'b0, 1'b0, 2'd0, 32'h0);
    vecs[3]  = mk(32'h01002021, 4'h0, 32'h0,        32'h0,        1'b0, 5'd0, 32'h0,        32'h8002000C, 32'h03A01021, 1'b1, 32'h80120000, 4'b0110, 1'b0, 1'b0, 2'd0, 32'h0);
    vecs[4]  = mk(32'h10000003, 4'h0, 32'h0,        32'h0,        1'b0, 5'd0, 32'h0,        32'h80020010, 32'h01002021, 1'b1, 32'h00000005, 4'b0110, 1'b0, 1'b0, 2'd0, 32'h0);
    vecs[5]  = mk(32'h03E01821, 4'h0, 32'h0,        32'h0,        1'b0, 5'd0, 32'h0,        32'h80020014, 32'h10000003, 1'b0, 32'h00000000, 4'b0000, 1'b0, 1'b1, 2'd1, 32'h80020020);
    vecs[6]  = mk(32'h08008010, 4'h0, 32'h0,        32'h0,        1'b0, 5'd0, 32'h0,        32'h80020020, 32'h00000000, 1'b1, 32'h00000000, 4'b0000, 1'b0, 1'b0, 2'd0, 32'h0);
    vecs[7]  = mk(32'h03E01821, 4'h0, 32'h0,        32'h0,        1'b0, 5'd0, 32'h0,        32'h80020024, 32'h08008010, 1'b0, 32'h00000000, 4'b0000, 1'b0, 1'b1, 2'd1, 32'h80020040);
    vecs[8]  = mk(32'h03E01821, 4'h0, 32'h0,        32'h0,        1'b0, 5'd0, 32'h0,        32'h80020040, 32'h00000000, 1'b1, 32'h00000000, 4'b0000, 1'b0, 1'b0, 2'd0, 32'h0);
    vecs[9]  = mk(32'h8C080000, 4'h0, 32'h0,        32'h0,        1'b0, 5'd0, 32'h0,        32'h80020044, 32'h03E01821, 1'b1, 32'hDEADBEEF, 4'b0110, 1'b0, 1'b0, 2'd0, 32'h0);
    vecs[10] = mk(32'h01004821, 4'h0, 32'h0,        32'h0,        1'b0, 5'd0, 32'h0,        32'h80020048, 32'h8C080000, 1'b1, 32'h00000000, 4'b0101, 1'b1, 1'b0, 2'd0, 32'h0);
    vecs[11] = mk(32'h01004821, 4'h0, 32'h0,        32'h0,        1'b0, 5'd0, 32'h0,        32'h80020048, 32'h00000000, 1'b1, 32'h00000000, 4'b0000, 1'b0, 1'b0, 2'd0, 32'h0);
    vecs[12] = mk(32'h8C080000, 4'h0, 32'h0,        32'h0,        1'b0, 5'd0, 32'h0,        32'h8002004C, 32'h01004821, 1'b1, 32'h00000005, 4'b0110, 1'b0, 1'b0, 2'd0, 32'h0);
    vecs[13] = mk(32'hAC080004, 4'h0, 32'h0,        32'h0,        1'b0, 5'd0, 32'h0,        32'h80020050, 32'h8C080000, 1'b1, 32'h00000000, 4'b0101, 1'b0, 1'b0, 2'd0, 32'h0);
    vecs[14] = mk(32'h01400008, 4'h0, 32'h0,        32'h0,        1'b0, 5'd0, 32'h0,        32'h80020054, 32'hAC080004, 1'b1, 32'h00000004, 4'b1000, 1'b0, 1'b0, 2'd2, 32'h5);
    vecs[15] = mk(32'h00000000, 4'h4, 32'h0,        32'h80020100, 1'b0, 5'd0, 32'h0,        32'h80020058, 32'h01400008, 1'b0, 32'h00000000, 4'b0000, 1'b0, 1'b1, 2'd1, 32'h80020100);
    vecs[16] = mk(32'h3C051234, 4'h0, 32'h0,        32'h0,        1'b0, 5'd0, 32'h0,        32'h80020100, 32'h00000000, 1'b1, 32'h00000000, 4'b0000, 1'b0, 1'b0, 2'd0, 32'h0);
    vecs[17] = mk(32'h00003021, 4'h0, 32'h0,        32'h0,        1'b1, 5'd0, 32'hFFFFFFFF, 32'h80020104, 32'h3C051234, 1'b1, 32'h12340000, 4'b0100, 1'b0, 1'b0, 2'd0, 32'h0);
    vecs[18] = mk(32'h00A03821, 4'h0, 32'h0,        32'h0,        1'b1, 5'd5, 32'hFFFFFFFF, 32'h80020108, 32'h00003021, 1'b1, 32'h00000000, 4'b0110, 1'b0, 1'b0, 2'd0, 32'h0);
    vecs[19] = mk(32'h00A0382A, 4'h0, 32'h0,        32'h0,        1'b0, 5'd0, 32'h0,        32'h8002010C, 32'h00A03821, 1'b1, 32'hFFFFFFFF, 4'b0110, 1'b0, 1'b0, 2'd0, 32'h0);
    vecs[20] = mk(32'h00053902, 4'h0, 32'h0,        32'h0,        1'b0, 5'd0, 32'h0,        32'h80020110, 32'h00A0382A, 1'b1, 32'h00000001, 4'b0110, 1'b0, 1'b0, 2'd0, 32'h0);
    vecs[21] = mk(32'h00053A00, 4'h0, 32'h0,        32'h0,        1'b0, 5'd0, 32'h0,        32'h80020114, 32'h00053902, 1'b1, 32'h0FFFFFFF, 4'b0110, 1'b0, 1'b0, 2'd0, 32'h0);
    vecs[22] = mk(32'h01053823, 4'h0, 32'h0,        32'h0,        1'b0, 5'd0, 32'h0,        32'h80020118, 32'h00053A00, 1'b1, 32'hFFFFFF00, 4'b0110, 1'b0, 1'b0, 2'd0, 32'h0);
    vecs[23] = mk(32'h00A83826, 4'h0, 32'h0,        32'h0,        1'b0, 5'd0, 32'h0,        32'h8002011C, 32'h01053823, 1'b1, 32'h00000006, 4'b0110, 1'b0, 1'b0, 2'd0, 32'h0);
    vecs[24] = mk(32'h1500FFFE, 4'h0, 32'h0,        32'h0,        1'b0, 5'd0, 32'h0,        32'h80020120, 32'h00A83826, 1'b1, 32'hFFFFFFFA, 4'b0110, 1'b0, 1'b0, 2'd0, 32'h0);
    vecs[25] = mk(32'h00000000, 4'h0, 32'h0,        32'h0,        1'b0, 5'd0, 32'h0,        32'h80020124, 32'h1500FFFE, 1'b0, 32'h00000000, 4'b0000, 1'b0, 1'b1, 2'd1, 32'h8002011C);
    vecs[26] = mk(32'h11000005, 4'h0, 32'h0,        32'h0,        1'b0, 5'd0, 32'h0,        32'h8002011C, 32'h00000000, 1'b1, 32'h00000000, 4'b0000, 1'b0, 1'b0, 2'd0, 32'h0);
    vecs[27] = mk(32'hFC000000, 4'h0, 32'h0,        32'h0,        1'b0, 5'd0, 32'h0,        32'h80020120, 32'h11000005, 1'b0, 32'h00000000, 4'b0000, 1'b0, 1'b0, 2'd0, 32'h0);
    vecs[28] = mk(32'h00000000, 4'h0, 32'h0,        32'h0,        1'b0, 5'd0, 32'h0,        32'h80020124, 32'hFC000000, 1'b1, 32'h00000000, 4'b0000, 1'b0, 1'b0, 2'd0, 32'h0);

    reset = 1'b1;
    drive_idle();
    repeat (2) @(negedge clock);
    reset = 1'b0;

    check("access_size", 0, {30'h0, i_access_size}, 32'h0);
    check("rw", 0, {31'h0, i_rw}, 32'h1);
    check("mem_enable", 0, {31'h0, i_mem_enable}, 32'h1);

    for (int i = 0; i < NV; i++) begin
      i_data_out = vecs[i].instr;
      {do_mx_bypass, do_wx_bypass, do_mx_bypass_b, do_wx_bypass_b} = vecs[i].byp;
      mx_data = vecs[i].mx; wx_data = vecs[i].wx;
      wb_we = vecs[i].wbe; wb_rd = vecs[i].wbrd; wb_data = vecs[i].wbd;
      #2;
      check("i_address", i, i_address, vecs[i].e_addr);
      check("ir_dx", i, ir_dx, vecs[i].e_ir);
      check("ctl_dx", i, {28'h0, dmwe_dx, rwe_dx, rdst_dx, rwd_dx}, {28'h0, vecs[i].e_ctl});
      check("stall", i, {31'h0, stall}, {31'h0, vecs[i].e_stall});
      check("do_branch", i, {31'h0, do_branch}, {31'h0, vecs[i].e_br});
      if (vecs[i].chk_alu) check("aluOut", i, aluOut, vecs[i].e_alu);
      if (vecs[i].aux_sel == 2'd1) check("pc_effective", i, pc_effective, vecs[i].e_aux);
      if (vecs[i].aux_sel == 2'd2) check("rBOut", i, rBOut, vecs[i].e_aux);
      @(negedge clock);
    end

    // Reset asserted while a load-use stall is pending.
    drive_idle();
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    i_data_out = 32'h8C080000;
    @(negedge clock);
    i_data_out = 32'h01004821;
    #2;
    check("rst_stall_pre", 0, {31'h0, stall}, 32'h1);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    i_data_out = 32'h08008010;
    #2;
    check("rst_stall_addr", 0, i_address, 32'h80020000);
    check("rst_stall_ir", 0, ir_dx, 32'h0);
    check("rst_stall_st", 0, {31'h0, stall}, 32'h0);
    @(negedge clock);

    // Reset asserted while a J redirect is being taken; also clears written registers.
    i_data_out = 32'h0;
    #2;
    check("rst_br_pre", 0, {31'h0, do_branch}, 32'h1);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    i_data_out = 32'h01051021;
    #2;
    check("rst_br_addr", 0, i_address, 32'h80020000);
    check("rst_br_ir", 0, ir_dx, 32'h0);
    check("rst_br_br", 0, {31'h0, do_branch}, 32'h0);
    @(negedge clock);
    i_data_out = 32'h0;
    #2;
    check("rst_regs_ir", 0, ir_dx, 32'h01051021);
    check("rst_regs_alu", 0, aluOut, 32'h0);
    check("rst_regs_addr", 0, i_address, 32'h80020004);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
